// File: rtl/dff_bank_pkg.sv
// Shared constants and pointer helper for the arbitrated register bank.
package dff_bank_pkg;

    localparam int NUM_REQ_MAX    = 8;
    localparam int DEFAULT_DATA_W = 8;

    function automatic int unsigned ptr_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: search starts at ptr and wraps upward.
module rr_arbiter
    import dff_bank_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(N);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Register bank shared by NUM_REQ writers through a round-robin arbiter,
// with a registered read port that also reports the last writer of each entry.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int                NUM_REQ = 4,
    parameter int                DATA_W  = DEFAULT_DATA_W,
    parameter int                ADDR_W  = 2,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic [$clog2(NUM_REQ)-1:0]  rd_owner,
    output logic                        wr_fire
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] bank  [DEPTH];
    logic [PTR_W-1:0]  owner [DEPTH];
    logic [PTR_W-1:0]  ptr;

    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               fire;

    logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign fire      = |gnt;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign wr_addr = addr_arr[gnt_idx];
    assign wr_data = data_arr[gnt_idx];

    // Read samples the pre-edge bank, so a same-cycle write shows up one edge later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < DEPTH; a++) begin
                bank[a]  <= RST_VAL;
                owner[a] <= '0;
            end
            ptr      <= '0;
            rd_data  <= RST_VAL;
            rd_owner <= '0;
            wr_fire  <= 1'b0;
        end else begin
            rd_data  <= bank[rd_addr];
            rd_owner <= owner[rd_addr];
            wr_fire  <= fire;
            if (fire) begin
                bank[wr_addr]  <= wr_data;
                owner[wr_addr] <= gnt_idx;
                ptr            <= PTR_W'(ptr_inc(32'(gnt_idx), NUM_REQ));
            end
        end
    end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench for dff_bank_arbiter with hand-computed expectations.
module tb_dff_bank_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic [1:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [1:0]  rd_owner;
    logic        wr_fire;

    int n_cmp = 0;
    int n_err = 0;

    dff_bank_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8),
        .ADDR_W  (2),
        .RST_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_owner  (rd_owner),
        .wr_fire   (wr_fire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [1:0] a, input logic [7:0] d);
        req_addr[i*2 +: 2] = a;
        req_data[i*8 +: 8] = d;
    endtask

    initial begin
        // Reset asserted mid-cycle: outputs clear without a clock edge
        tick();
        tick();
        #2;
        rd_addr = 2'd2;
        rstn = 1'b0;
        #1;
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_rd_owner", 32'(rd_owner), 32'd0);
        chk("rst_wr_fire", 32'(wr_fire), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        tick();
        #2;
        rstn = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            tick();
            chk($sformatf("rst_read_%0d", a), 32'(rd_data), 32'h00);
            chk($sformatf("rst_owner_%0d", a), 32'(rd_owner), 32'd0);
        end

        // Round robin with all four requesting, ptr starts at 0
        for (int i = 0; i < 4; i++) drive(i, 2'(i), 8'h10 + 8'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr_fire_%0d", k), 32'(wr_fire), 32'd1);
        end
        req_valid = 4'b0000;
        rd_addr = 2'd3;
        tick();
        chk("rr_rd_data3", 32'(rd_data), 32'h13);
        chk("rr_rd_owner3", 32'(rd_owner), 32'd3);
        chk("idle_wr_fire", 32'(wr_fire), 32'd0);

        // Single writer (ptr = 0)
        drive(0, 2'd1, 8'hA5);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        tick();
        chk("single_fire", 32'(wr_fire), 32'd1);
        req_valid = 4'b0000;
        rd_addr = 2'd1;
        tick();
        chk("single_rd_data", 32'(rd_data), 32'hA5);
        chk("single_rd_owner", 32'(rd_owner), 32'd0);
        chk("single_fire_drop", 32'(wr_fire), 32'd0);

        // Pointer skip and wrap: ptr=1, grant to 2 moves ptr to 3
        drive(2, 2'd0, 8'h77);
        req_valid = 4'b0100;
        #1;
        chk("skip_first", 32'(req_ready), 32'h4);
        tick();
        drive(0, 2'd2, 8'h55);
        drive(2, 2'd0, 8'h66);
        req_valid = 4'b0101;
        #1;
        chk("wrap_grant0", 32'(req_ready), 32'h1);
        tick();
        #1;
        chk("wrap_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        rd_addr = 2'd0;
        tick();
        chk("wrap_rd0", 32'(rd_data), 32'h66);
        chk("wrap_owner0", 32'(rd_owner), 32'd2);

        // Back-to-back throughput for a lone requester (ptr = 3)
        drive(3, 2'd2, 8'hE1);
        req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("b2b_ready_%0d", k), 32'(req_ready), 32'h8);
            tick();
            chk($sformatf("b2b_fire_%0d", k), 32'(wr_fire), 32'd1);
        end
        req_valid = 4'b0000;

        // Read-during-write: seed addr 3 with 0x11 via requester 1 (ptr = 0)
        drive(1, 2'd3, 8'h11);
        req_valid = 4'b0010;
        #1;
        chk("rdw_seed_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        rd_addr = 2'd3;
        tick();
        chk("rdw_seed_data", 32'(rd_data), 32'h11);
        drive(2, 2'd3, 8'h22);
        req_valid = 4'b0100;
        tick();
        chk("rdw_old_data", 32'(rd_data), 32'h11);
        chk("rdw_old_owner", 32'(rd_owner), 32'd1);
        req_valid = 4'b0000;
        tick();
        chk("rdw_new_data", 32'(rd_data), 32'h22);
        chk("rdw_new_owner", 32'(rd_owner), 32'd2);

        // Reset during contention: ptr=3, move it to 2 via requester 1
        drive(1, 2'd0, 8'h99);
        req_valid = 4'b0010;
        tick();
        drive(1, 2'd1, 8'hC3);
        drive(3, 2'd2, 8'h3C);
        req_valid = 4'b1010;
        #1;
        chk("cont_pre_grant", 32'(req_ready), 32'h8);
        #1;
        rstn = 1'b0;
        tick();
        chk("cont_rst_fire", 32'(wr_fire), 32'd0);
        #2;
        rstn = 1'b1;
        #1;
        chk("cont_post_grant", 32'(req_ready), 32'h2);
        rd_addr = 2'd2;
        tick();
        chk("cont_fire", 32'(wr_fire), 32'd1);
        chk("cont_no_partial", 32'(rd_data), 32'h00);
        #1;
        chk("cont_next_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        rd_addr = 2'd1;
        tick();
        chk("cont_rd1", 32'(rd_data), 32'hC3);
        chk("cont_owner1", 32'(rd_owner), 32'd1);
        rd_addr = 2'd2;
        tick();
        chk("cont_rd2", 32'(rd_data), 32'h3C);
        chk("cont_owner2", 32'(rd_owner), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
